// File: rtl/exu_stage_pkg.sv
// Shared definitions for the RV32I execute stage: widths, instruction kinds,
// ALU funct3 codes and the operand-register bundle layout.
package exu_stage_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [2:0] KIND_OP    = 3'd0;
  localparam logic [2:0] KIND_OPIMM = 3'd1;
  localparam logic [2:0] KIND_LUI   = 3'd2;
  localparam logic [2:0] KIND_AUIPC = 3'd3;
  localparam logic [2:0] KIND_LINK  = 3'd4;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] FUNCT7_SUB  = 7'h20;
  localparam logic [6:0] FUNCT7_NONE = 7'h00;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      kind;
    logic [RA_W-1:0] rd;
    logic            wen;
  } a_entry_t;

endpackage

// File: rtl/exu_stage_alu.sv
// Combinational RV32I integer ALU; funct7 == SUB selects subtract / arithmetic shift.
module exu_stage_alu
  import exu_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  logic                   alt;
  logic [4:0]             shamt;
  logic signed [XLEN-1:0] sra_v;
  logic [XLEN-1:0]        srl_v;

  always_comb begin
    alt    = (funct7 == FUNCT7_SUB);
    shamt  = op_b[4:0];
    sra_v  = $signed(op_a) >>> shamt;
    srl_v  = op_a >> shamt;
    result = '0;
    case (funct3)
      F3_ADD:  result = alt ? (op_a - op_b) : (op_a + op_b);
      F3_SLL:  result = op_a << shamt;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      F3_XOR:  result = op_a ^ op_b;
      F3_SR:   result = alt ? sra_v : srl_v;
      F3_OR:   result = op_a | op_b;
      F3_AND:  result = op_a & op_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exu_stage.sv
// Two-register execute stage: A holds the decoded operand bundle, B holds the
// result bundle for writeback. Full throughput, back-pressure, synchronous flush.
module exu_stage
  import exu_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [2:0]      in_kind,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_wen,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RA_W-1:0] out_rd,
  output logic            out_wen
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds payload while valid & ~ready.

  a_entry_t        a_q, a_d;
  logic            a_valid_q, a_valid_d;
  logic            b_valid_q, b_valid_d;
  logic [XLEN-1:0] b_result_q, b_result_d;
  logic [RA_W-1:0] b_rd_q, b_rd_d;
  logic            b_wen_q, b_wen_d;

  logic            a_adv;
  logic            in_fire;
  logic [2:0]      alu_f3;
  logic [6:0]      alu_f7;
  logic [XLEN-1:0] alu_a, alu_b, alu_res, link_sum, stage_res;

  always_comb begin
    alu_a  = a_q.rs1;
    alu_b  = a_q.rs2;
    alu_f3 = a_q.funct3;
    alu_f7 = a_q.funct7;
    case (a_q.kind)
      KIND_OPIMM: begin
        alu_b  = a_q.imm;
        // Only SRAI carries a real funct7 bit (imm[10]); ADDI must never subtract.
        alu_f7 = (a_q.funct3 == F3_SR && a_q.imm[10]) ? FUNCT7_SUB : FUNCT7_NONE;
      end
      KIND_AUIPC: begin
        alu_a  = a_q.pc;
        alu_b  = a_q.imm;
        alu_f3 = F3_ADD;
        alu_f7 = FUNCT7_NONE;
      end
      default: ;
    endcase
  end

  exu_stage_alu u_alu (
    .funct3 (alu_f3),
    .funct7 (alu_f7),
    .op_a   (alu_a),
    .op_b   (alu_b),
    .result (alu_res)
  );

  always_comb begin
    link_sum = a_q.pc + XLEN'(4);
    case (a_q.kind)
      KIND_LUI:  stage_res = a_q.imm;
      KIND_LINK: stage_res = link_sum;
      default:   stage_res = alu_res;
    endcase
  end

  always_comb begin
    a_adv    = a_valid_q & (~b_valid_q | out_ready);
    in_ready = ~flush & (~a_valid_q | a_adv);
    in_fire  = in_valid & in_ready;

    a_valid_d = flush ? 1'b0 : (in_fire | (a_valid_q & ~a_adv));
    b_valid_d = flush ? 1'b0 : (a_adv | (b_valid_q & ~out_ready));

    a_d = a_q;
    if (in_fire) begin
      a_d.pc     = in_pc;
      a_d.rs1    = in_rs1;
      a_d.rs2    = in_rs2;
      a_d.imm    = in_imm;
      a_d.funct3 = in_funct3;
      a_d.funct7 = in_funct7;
      a_d.kind   = in_kind;
      a_d.rd     = in_rd;
      a_d.wen    = in_wen;
    end

    b_result_d = b_result_q;
    b_rd_d     = b_rd_q;
    b_wen_d    = b_wen_q;
    if (a_adv) begin
      b_result_d = stage_res;
      b_rd_d     = a_q.rd;
      b_wen_d    = a_q.wen & (a_q.rd != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_result_q <= '0;
      b_rd_q     <= '0;
      b_wen_q    <= 1'b0;
    end else begin
      a_q        <= a_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      b_result_q <= b_result_d;
      b_rd_q     <= b_rd_d;
      b_wen_q    <= b_wen_d;
    end
  end

  assign out_valid  = b_valid_q;
  assign out_result = b_result_q;
  assign out_rd     = b_rd_q;
  assign out_wen    = b_wen_q;

endmodule

// File: tb/tb_exu_stage.sv
// Self-checking bench for exu_stage: a queue-based behavioural model of the
// in-flight instructions checked every cycle, plus directed literal cases.
module tb_exu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_outfire = 0;

  // Each expected entry is {result, rd, wen}; acc_q holds the accept cycle.
  logic [37:0] exp_q[$];
  int          acc_q[$];

  exu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_kind(in_kind),
    .in_rd(in_rd), .in_wen(in_wen), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] shifted;
    sa = a;
    shifted = sa >>> b[4:0];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? shifted : (a >> b[4:0]);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [37:0] ref_out();
    logic [31:0] r;
    case (in_kind)
      3'd1: r = alu_ref(in_funct3, (in_funct3 == 3'd5) && in_imm[10], in_rs1, in_imm);
      3'd2: r = in_imm;
      3'd3: r = in_pc + in_imm;
      3'd4: r = in_pc + 32'd4;
      default: r = alu_ref(in_funct3, in_funct7 == 7'h20, in_rs1, in_rs2);
    endcase
    return {r, in_rd, in_wen && (in_rd != 5'd0)};
  endfunction

  // Model + compare: at most two instructions in flight; the oldest is visible
  // one edge after its accept; input is accepted unless two are held and
  // writeback stalls.
  initial begin
    logic        e_ov, e_ir, do_in, do_out, do_fl;
    logic [37:0] pend;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_wen", out_wen, 0);
        exp_q.delete();
        acc_q.delete();
        continue;
      end
      e_ov = (exp_q.size() > 0) && (cyc > acc_q[0]);
      e_ir = !flush && (exp_q.size() < 2 || out_ready);
      chk("in_ready", in_ready, e_ir);
      chk("out_valid", out_valid, e_ov);
      if (e_ov && out_valid) begin
        chk("out_result", out_result, exp_q[0][37:6]);
        chk("out_rd", out_rd, exp_q[0][5:1]);
        chk("out_wen", out_wen, exp_q[0][0]);
      end
      do_in  = in_valid && e_ir;
      do_out = e_ov && out_ready;
      do_fl  = flush;
      pend   = ref_out();
      @(posedge clk);
      cyc++;
      if (rst || do_fl) begin
        exp_q.delete();
        acc_q.delete();
        continue;
      end
      if (do_out) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        n_outfire++;
      end
      if (do_in) begin
        exp_q.push_back(pend);
        acc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_in(input logic [2:0] kind, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic wen);
    in_kind = kind; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_funct3 = f3; in_funct7 = f7; in_rd = rd; in_wen = wen;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send();
    bit ok = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk);
      #1;
    end
    chk("send_accept", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One instruction into an empty stage: checks latency and the literal result.
  task automatic directed(input string name, input logic [31:0] exp_res, input logic exp_wen);
    int lat = 0;
    send();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_result"}, out_result, exp_res);
    chk({name, "_wen"}, out_wen, exp_wen);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    bit drop;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    set_in(3'd1, 32'h0, 32'd5, 32'h0, 32'hFFFFFC00, 3'd0, 7'h00, 5'd1, 1'b1);
    directed("addi", 32'hFFFFFC05, 1'b1);
    set_in(3'd1, 32'h0, 32'h80000000, 32'h0, 32'h404, 3'd5, 7'h00, 5'd2, 1'b1);
    directed("srai", 32'hF8000000, 1'b1);
    set_in(3'd1, 32'h0, 32'h80000000, 32'h0, 32'h004, 3'd5, 7'h00, 5'd3, 1'b1);
    directed("srli", 32'h08000000, 1'b1);
    set_in(3'd4, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 3'd0, 7'h00, 5'd0, 1'b1);
    directed("link_rd0", 32'h00000000, 1'b0);
    set_in(3'd2, 32'h0, 32'h0, 32'h0, 32'h12345000, 3'd0, 7'h00, 5'd4, 1'b1);
    directed("lui", 32'h12345000, 1'b1);
    set_in(3'd3, 32'h1000, 32'h0, 32'h0, 32'h2000, 3'd0, 7'h00, 5'd5, 1'b1);
    directed("auipc", 32'h00003000, 1'b1);

    // Eight back-to-back adds with writeback always ready.
    start = n_outfire;
    drop = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(3'd0, 32'h0, i * 3, 32'd100, 32'h0, 3'd0, 7'h00, 5'(i + 1), 1'b1);
      in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) drop = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_in_ready_held", drop, 0);
    chk("b2b_outfires", n_outfire - start, 8);

    // Fill both registers, then release exactly one result.
    out_ready = 1'b0;
    set_in(3'd0, 32'h0, 32'd7, 32'd8, 32'h0, 3'd0, 7'h20, 5'd9, 1'b1);
    send();
    set_in(3'd0, 32'h0, 32'd1, 32'd2, 32'h0, 3'd4, 7'h00, 5'd10, 1'b1);
    send();
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    start = n_outfire;
    @(negedge clk);
    chk("pulse_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pulse_one_fire", n_outfire - start, 1);
    chk("pulse_out_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // Refill A, then flush with an instruction offered.
    set_in(3'd0, 32'h0, 32'd3, 32'd4, 32'h0, 3'd6, 7'h00, 5'd11, 1'b1);
    send();
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Async reset in the middle of a stream.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(3'd0, 32'h0, 32'h100 + i, 32'h11, 32'h0, 3'd0, 7'h00, 5'd7, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_result", out_result, 0);
    chk("async_rst_out_rd", out_rd, 0);
    chk("async_rst_out_wen", out_wen, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic with back-pressure and occasional flush.
    for (int i = 0; i < 1500; i++) begin
      set_in(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2047)),
             3'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_stage.md
# exu_stage

Registered execute stage of the RV32I core pipeline. Accepts one decoded instruction per cycle from decode over a valid/ready handshake and latches it into an operand register. It selects ALU operands (register, immediate or PC) and normalises funct7 for immediate forms. It drives the combinational ALU32 unit and registers the result, destination register and write-enable for the writeback stage, with full throughput and back-pressure.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register-address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2  in  XLEN  register operands
- in_imm  in  XLEN  sign-extended immediate
- in_funct3  in  3  ALU operation select
- in_funct7  in  7  ALU sub-select (R-type)
- in_kind  in  3  0=OP, 1=OP-IMM, 2=LUI, 3=AUIPC, 4=LINK (JAL/JALR); 5-7 behave as OP
- in_rd  in  RA_W  destination register
- in_wen  in  1  instruction writes rd
- flush  in  1  synchronous kill of all in-flight entries
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback accepts
- out_result  out  XLEN  result
- out_rd  out  RA_W  destination register
- out_wen  out  1  write-enable (forced 0 when out_rd==0)

## Operation
- Two registers: A (operand/control bundle, a_valid) and B (result bundle, b_valid = out_valid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; a_adv = a_valid & (~b_valid | out_ready).
- in_ready = ~flush & (~a_valid | a_adv); purely combinational from out_ready, a_valid, b_valid, flush.
- Operand select from A:
  - OP: in1=rs1, in2=rs2, funct7 passed through.
  - OP-IMM: in1=rs1, in2=imm; ALU funct7=0x20 only if funct3==5 and imm[10]==1, else 0x00. ADDI never subtracts.
  - AUIPC: in1=pc, in2=imm, funct3=0, funct7=0.
  - LUI: result=imm; ALU output ignored.
  - LINK: result=pc+4 (own adder, mod 2^XLEN); ALU output ignored.
- All arithmetic wraps mod 2^XLEN; no overflow flags.
- B loads {result, rd, wen & (rd!=0)} on a_adv; b_valid next = a_adv | (b_valid & ~out_ready).
- A loads on in_fire; a_valid next = in_fire | (a_valid & ~a_adv).
- flush: next cycle a_valid=0 and b_valid=0. Overrides simultaneous in_valid, a_adv and out_fire. Decode must not count an instruction as accepted in a flush cycle.
- B payload holds stable while out_valid & ~out_ready. A payload holds while a_valid & ~a_adv.

## Timing
- Reset (async assert, any cycle, mid-transfer included): a_valid=0, b_valid=0, out_result=0, out_rd=0, out_wen=0. A payload also 0. in_ready=1 on first cycle after deassert, unless flush is high.
- Latency: in_fire at edge N gives out_valid high after edge N+1.
- Throughput: 1/cycle with out_ready held high.
- Full (both A and B valid, out_ready=0): in_ready=0. Single out_ready pulse moves A into B and frees A in the same edge.
- Empty: out_valid=0; out_result/out_rd/out_wen keep last values (don't-care).
- Simultaneous in_fire and a_adv: A takes new entry, B takes old A.

## Structure
- Shared core package: XLEN, RA_W, kind encodings (KIND_OP..KIND_LINK), funct3 ALU codes, FUNCT7_SUB=0x20.
- Sub-module: one ALU32 instance, fed from A's selected operands. Operand selection and funct7 normalisation stay in this block.
- No other sub-modules.

## Test plan
- OP-IMM addi rs1=5, imm=0xFFFFFC00 (bit10 set), funct3=0 -> out_result=0xFFFFFC05 (no subtract), out_valid 2 cycles after accept.
- OP-IMM srai rs1=0x80000000, imm=0x404, funct3=5 -> 0xF8000000; same with imm=0x004 (srli) -> 0x08000000.
- Back-to-back 8 OP adds with out_ready=1 -> 8 results on consecutive cycles, in order, in_ready never drops.
- Fill with out_ready=0 -> in_ready=0 after 2 accepts; pulse out_ready once -> one out_fire, in_ready=1 that cycle, no loss/duplication.
- LINK pc=0xFFFFFFFC, rd=0 -> out_result=0x00000000, out_wen=0. LUI imm=0x12345000 -> 0x12345000. AUIPC pc=0x1000, imm=0x2000 -> 0x3000.
- flush with in_valid=1 and both stages full -> in_ready=0, next cycle out_valid=0. Async rst mid-stream -> all outputs 0 immediately.
